// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by the 1:16 demultiplexer and the 16:1 multiplexer.
// Holds the default frame geometry and the receiver/transmitter state encoding.
package tdm_pkg;

    // Default frame geometry: 16 slots per frame, 4-bit slot index.
    localparam int TDM_CHANNELS   = 16;
    localparam int TDM_SLOT_WIDTH = 4;

    // Framing state: IDLE waits for a frame sync, RUN tracks slots.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

    // Slot index of the last slot in a frame, sized to the slot index width.
    function automatic logic [TDM_SLOT_WIDTH-1:0] tdm_last_slot();
        return TDM_SLOT_WIDTH'(TDM_CHANNELS - 1);
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter.
// - inc_in advances the count, wrapping CHANNELS-1 -> 0.
// - load1_in forces the count to 1 (slot 0 was just consumed by a sync).
// - tc_out flags the last slot of the frame from the current count.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = TDM_CHANNELS,
    parameter int SLOT_WIDTH = TDM_SLOT_WIDTH
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  inc_in,
    input  logic                  load1_in,
    output logic [SLOT_WIDTH-1:0] count_out,
    output logic                  tc_out
);

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(CHANNELS - 1);
    localparam logic [SLOT_WIDTH-1:0] ONE_SLOT  = SLOT_WIDTH'(1);

    logic [SLOT_WIDTH-1:0] count_q;
    logic [SLOT_WIDTH-1:0] count_d;
    logic                  tc;

    assign tc = (count_q == LAST_SLOT);

    // Next count: load-to-1 wins over increment; increment wraps at the last slot.
    always_comb begin
        count_d = count_q;
        if (load1_in) begin
            count_d = ONE_SLOT;
        end else if (inc_in) begin
            if (tc) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE_SLOT;
            end
        end
    end

    // Count register with synchronous reset to slot 0.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tc_out    = tc;

endmodule : tdm_slot_counter

// File: rtl/tdm_demux_1_16.sv
// 1:16 TDM serial demultiplexer.
// Serial bits arrive one slot per enabled cycle; a frame sync marks slot 0.
// Bits are collected into a shadow register and the whole frame is copied to
// the output register on the edge that samples the last slot, so the parallel
// output only ever shows complete frames. A sync seen away from slot 0 flags a
// framing error, drops the partial frame and restarts at slot 1.
module tdm_demux_1_16
    import tdm_pkg::*;
#(
    parameter int CHANNELS   = TDM_CHANNELS,
    parameter int SLOT_WIDTH = TDM_SLOT_WIDTH
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Frame_Sync_In,
    input  logic                  Data_In,
    input  logic                  Output_Enable_In,
    output logic [CHANNELS-1:0]   Channel_Data_Out,
    output logic                  Frame_Valid_Out,
    output logic [SLOT_WIDTH-1:0] Slot_Out,
    output logic                  Frame_Error_Out,
    output logic                  Locked_Out
);

    tdm_state_e            state_q;
    tdm_state_e            state_d;
    logic [CHANNELS-1:0]   shadow_q;
    logic [CHANNELS-1:0]   shadow_d;
    logic [CHANNELS-1:0]   chan_q;
    logic [CHANNELS-1:0]   chan_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  error_q;
    logic                  error_d;

    logic [SLOT_WIDTH-1:0] slot;
    logic                  slot_tc;
    logic                  slot_is_zero;
    logic                  cnt_inc;
    logic                  cnt_load1;

    tdm_slot_counter #(
        .CHANNELS   (CHANNELS),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_slot_counter (
        .clk       (Clock_In),
        .srst      (Reset_In),
        .inc_in    (cnt_inc),
        .load1_in  (cnt_load1),
        .count_out (slot),
        .tc_out    (slot_tc)
    );

    assign slot_is_zero = (slot == '0);

    // Framing FSM next state, shadow/output capture and counter control.
    // Nothing moves while Enable_In is low; the pulses default to 0 so they
    // only ever last one cycle and can never coincide.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        chan_d    = chan_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;

        if (Enable_In) begin
            case (state_q)
                ST_IDLE: begin
                    // Data without a sync is ignored until the first frame start.
                    if (Frame_Sync_In) begin
                        shadow_d[0] = Data_In;
                        cnt_load1   = 1'b1;
                        state_d     = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (Frame_Sync_In && !slot_is_zero) begin
                        // Misaligned sync: drop the partial frame, restart at slot 1.
                        error_d     = 1'b1;
                        shadow_d[0] = Data_In;
                        cnt_load1   = 1'b1;
                    end else begin
                        shadow_d[slot] = Data_In;
                        cnt_inc        = 1'b1;
                        if (slot_tc) begin
                            // Last slot: publish the frame on this same edge.
                            chan_d                = shadow_q;
                            chan_d[CHANNELS-1]    = Data_In;
                            valid_d               = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, shadow, output frame and pulse registers; reset wins over enable.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // Per-bit tristate driver; the output enable never touches internal state.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out_drv
        assign Channel_Data_Out[gi] = Output_Enable_In ? chan_q[gi] : 1'bz;
    end

    assign Frame_Valid_Out = valid_q;
    assign Frame_Error_Out = error_q;
    assign Slot_Out        = slot;
    assign Locked_Out      = (state_q == ST_RUN);

endmodule : tdm_demux_1_16

// File: tb/tb_tdm_demux_1_16.sv
// Self-checking bench for tdm_demux_1_16: directed frame scenarios followed by
// randomized traffic, all checked against a queue-based frame model.
module tb_tdm_demux_1_16;

    localparam int CH = 16;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          sync;
    logic          din;
    logic          oe;
    logic [CH-1:0] chan_out;
    logic          valid_out;
    logic [SW-1:0] slot_out;
    logic          error_out;
    logic          locked_out;

    tdm_demux_1_16 #(.CHANNELS(CH), .SLOT_WIDTH(SW)) dut (
        .Clock_In         (clk),
        .Reset_In         (rst),
        .Enable_In        (en),
        .Frame_Sync_In    (sync),
        .Data_In          (din),
        .Output_Enable_In (oe),
        .Channel_Data_Out (chan_out),
        .Frame_Valid_Out  (valid_out),
        .Slot_Out         (slot_out),
        .Frame_Error_Out  (error_out),
        .Locked_Out       (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits received since the last frame start, kept in a queue.
    bit            m_locked;
    bit            m_bits[$];
    logic [CH-1:0] m_frame;
    bit            m_valid;
    bit            m_error;
    int            valid_seen;
    int            error_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s, input bit d);
        m_valid = 0;
        m_error = 0;
        if (r) begin
            m_locked = 0;
            m_bits.delete();
            m_frame  = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    m_bits.delete();
                    m_bits.push_back(d);
                end
            end else if (s && m_bits.size() != 0) begin
                m_error = 1;
                m_bits.delete();
                m_bits.push_back(d);
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == CH) begin
                    for (int i = 0; i < CH; i++) m_frame[i] = m_bits[i];
                    m_valid = 1;
                    m_bits.delete();
                end
            end
        end
    endtask

    // One clock: apply inputs, clock, then compare every output against the model.
    task automatic step(input bit r, input bit e, input bit s, input bit d);
        logic [CH-1:0] zval;
        zval = 'z;
        rst  = r;
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
        model_step(r, e, s, d);
        if (valid_out) valid_seen++;
        if (error_out) error_seen++;
        chk("slot",   32'(slot_out),   32'(m_bits.size()));
        chk("locked", 32'(locked_out), 32'(m_locked));
        chk("valid",  32'(valid_out),  32'(m_valid));
        chk("error",  32'(error_out),  32'(m_error));
        chk("pulse_excl", 32'(valid_out & error_out), 32'd0);
        if (oe) chk("chan", 32'(chan_out), 32'(m_frame));
        else    chk("chan_z", 32'(chan_out), 32'(zval));
        $display("t=%0t rst=%0b en=%0b sync=%0b d=%0b slot=%0d lock=%0b val=%0b err=%0b chan=%h",
                 $time, r, e, s, d, slot_out, locked_out, valid_out, error_out, chan_out);
    endtask

    task automatic send_bits(input logic [CH-1:0] word, input int first, input int last,
                             input bit sync_first);
        for (int i = first; i <= last; i++)
            step(0, 1, (i == first) && sync_first, word[i]);
    endtask

    initial begin
        int v0;
        rst = 0; en = 0; sync = 0; din = 0; oe = 1;
        m_locked = 0; m_frame = '0; m_valid = 0; m_error = 0;
        valid_seen = 0; error_seen = 0;

        // Reset state.
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("reset_chan", 32'(chan_out), 32'h0);

        // Single frame 0xA5C3, LSB first.
        valid_seen = 0;
        send_bits(16'hA5C3, 0, 15, 1);
        chk("a5c3_frame", 32'(chan_out), 32'hA5C3);
        chk("a5c3_valid_cnt", 32'(valid_seen), 32'd1);
        chk("a5c3_locked", 32'(locked_out), 32'd1);

        // Back-to-back frames with sync on every slot 0.
        valid_seen = 0; error_seen = 0;
        send_bits(16'h1234, 0, 15, 1);
        v0 = $time;
        chk("b2b_first", 32'(chan_out), 32'h1234);
        send_bits(16'hFFFF, 0, 15, 1);
        chk("b2b_gap", 32'($time - v0), 32'd160);
        chk("b2b_second", 32'(chan_out), 32'hFFFF);
        chk("b2b_valid_cnt", 32'(valid_seen), 32'd2);
        chk("b2b_error_cnt", 32'(error_seen), 32'd0);

        // Sync at slot 7 mid-frame: error, old frame held, new frame completes.
        send_bits(16'h0F0F, 0, 6, 1);
        step(0, 1, 1, 1);
        chk("err7_pulse", 32'(error_out), 32'd1);
        chk("err7_hold", 32'(chan_out), 32'hFFFF);
        send_bits(16'h5A0F, 1, 15, 0);
        chk("err7_newframe", 32'(chan_out), 32'h5A0F);

        // Enable low for 5 cycles at slot 9 with sync toggling.
        send_bits(16'hC0DE, 0, 8, 1);
        for (int i = 0; i < 5; i++) step(0, 0, i[0], 1);
        chk("stall_slot", 32'(slot_out), 32'd9);
        send_bits(16'hC0DE, 9, 15, 0);
        chk("stall_frame", 32'(chan_out), 32'hC0DE);

        // Reset at slot 12, then unsynced data is ignored.
        send_bits(16'h9999, 0, 11, 1);
        step(1, 1, 0, 1);
        chk("rst12_chan", 32'(chan_out), 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1);
        chk("rst12_idle", 32'(locked_out), 32'd0);
        send_bits(16'h3C5A, 0, 15, 1);
        chk("rst12_frame", 32'(chan_out), 32'h3C5A);

        // Output disabled: high impedance, state keeps running, value intact afterwards.
        oe = 0;
        send_bits(16'h7E81, 0, 15, 1);
        oe = 1;
        step(0, 0, 0, 0);
        chk("oe_frame", 32'(chan_out), 32'h7E81);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit e, s, r;
            e = ($urandom_range(0, 9) < 8);
            if (m_bits.size() == 0) s = ($urandom_range(0, 9) < 7);
            else                    s = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 999) == 0);
            oe = ($urandom_range(0, 19) != 0);
            step(r, e, s, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux_1_16

// File: doc/tdm_demux_1_16.md
TDM_DEMUX_1_16 -- requirements
Module: tdm_demux_1_16

Interface
REQ-001 SHALL have parameter CHANNELS, default 16: number of time slots per frame and number of output channels.
REQ-002 SHALL have parameter SLOT_WIDTH, default 4: slot index width, equal to log2(CHANNELS).
REQ-003 Clock_In  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_In  input  1  reset; synchronous, active-high.
REQ-005 Enable_In  input  1  qualifies Data_In and Frame_Sync_In; low = stall, all state held.
REQ-006 Frame_Sync_In  input  1  marks the current Data_In bit as slot 0 of a frame.
REQ-007 Data_In  input  1  time-multiplexed serial data, one slot per enabled cycle.
REQ-008 Output_Enable_In  input  1  high drives Channel_Data_Out; low puts it at high-impedance.
REQ-009 Channel_Data_Out  output  CHANNELS  demultiplexed frame; bit k = slot k value.
REQ-010 Frame_Valid_Out  output  1  one-cycle pulse when Channel_Data_Out updates.
REQ-011 Slot_Out  output  SLOT_WIDTH  slot index expected on the next enabled cycle.
REQ-012 Frame_Error_Out  output  1  one-cycle pulse on sync misalignment.
REQ-013 Locked_Out  output  1  high while in RUN state.

Function
REQ-014 SHALL implement states IDLE and RUN; Locked_Out = (state == RUN).
REQ-015 IDLE: enabled cycle with Frame_Sync_In=1 -> store Data_In in shadow bit 0, Slot_Out=1, go RUN; otherwise Data_In is ignored.
REQ-016 RUN, enabled cycle, Frame_Sync_In=0: store Data_In in shadow bit Slot_Out, then Slot_Out increments modulo CHANNELS.
REQ-017 RUN, enabled cycle, Slot_Out=CHANNELS-1: shadow bits 0..CHANNELS-2 plus Data_In copy to the Channel_Data_Out register on the same edge; Frame_Valid_Out=1 next cycle; Slot_Out wraps to 0; stay RUN.
REQ-018 Latency: Channel_Data_Out and Frame_Valid_Out update on the clock edge that samples the slot CHANNELS-1 bit.
REQ-019 RUN, enabled cycle, Frame_Sync_In=1, Slot_Out=0: normal alignment; treat as REQ-016, no error.
REQ-020 RUN, enabled cycle, Frame_Sync_In=1, Slot_Out!=0: Frame_Error_Out=1 for one cycle; discard the partial frame (Channel_Data_Out unchanged, no Frame_Valid_Out); store Data_In in shadow bit 0; Slot_Out=1; stay RUN.
REQ-021 Enable_In=0: state, shadow, Slot_Out and Channel_Data_Out hold; Frame_Sync_In ignored; Frame_Valid_Out and Frame_Error_Out are 0.
REQ-022 Frame_Valid_Out and Frame_Error_Out SHALL never both be 1 in the same cycle.
REQ-023 Output_Enable_In affects only the output driver, never internal state.

Reset
REQ-024 With Reset_In=1 at a rising edge: state=IDLE, Slot_Out=0, shadow=0, Channel_Data_Out register=0, Frame_Valid_Out=0, Frame_Error_Out=0. Reset has priority over Enable_In.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first frame after reset requires a new Frame_Sync_In.

Structure
REQ-026 SHALL place state encoding (IDLE, RUN) and default CHANNELS/SLOT_WIDTH constants in the shared package tdm_pkg, reused by the matching tdm_mux_16_1 transmitter.
REQ-027 SHALL use one sub-module, tdm_slot_counter: modulo-CHANNELS counter with enable, load-to-1, and terminal-count output.

Verification
REQ-028 Reset, then sync + 16 enabled bits 0xA5C3 (LSB first) -> Channel_Data_Out=0xA5C3 with one Frame_Valid_Out pulse on the 16th edge; Locked_Out=1.
REQ-029 Two back-to-back frames 0x1234 then 0xFFFF, sync on each slot 0 -> two Frame_Valid_Out pulses 16 cycles apart; no Frame_Error_Out.
REQ-030 Sync at slot 7 mid-frame -> Frame_Error_Out pulse; previous output holds; the next 15 bits complete a new frame, which is output correctly.
REQ-031 Enable_In low for 5 cycles at slot 9 (sync toggled meanwhile) -> Slot_Out holds 9; the frame completes correctly 5 cycles late.
REQ-032 Reset_In pulsed at slot 12 -> all outputs 0, IDLE; data without sync is ignored until the next Frame_Sync_In.
REQ-033 Output_Enable_In=0 -> Channel_Data_Out all Z; after re-enable, the last valid frame value is visible unchanged.
